// File: rtl/bench_step_arbiter_if.sv
// Requester/response bundle for the bench step arbiter: two step-vector
// requesters on one side, a single response stream on the other.
`timescale 1ns/1ps
interface bench_step_arbiter_if;
    logic [1:0]  req_valid;
    logic [17:0] req_x0;
    logic [17:0] req_x1;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        rsp_valid;
    logic        rsp_id;
    logic [38:0] rsp_y;
    logic [7:0]  rsp_step;
    logic        rsp_last;
    logic        rsp_timeout;

    modport master (
        output req_valid, req_x0, req_x1, req_last,
        input  req_ready, grant, rsp_valid, rsp_id, rsp_y, rsp_step,
               rsp_last, rsp_timeout
    );

    modport slave (
        input  req_valid, req_x0, req_x1, req_last,
        output req_ready, grant, rsp_valid, rsp_id, rsp_y, rsp_step,
               rsp_last, rsp_timeout
    );
endinterface

// File: rtl/bench_step_arbiter.sv
// Round-robin arbiter granting two requesters exclusive step-by-step sessions
// on a clock-gated DUT; every output is registered.
`timescale 1ns/1ps
module bench_step_arbiter #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    bench_step_arbiter_if.slave   bus,
    output logic                  dut_rst,
    output logic [17:0]           dut_x,
    output logic                  dut_clk_en,
    input  logic [38:0]           dut_y
);

    typedef enum logic [2:0] {IDLE, RESET, WAIT, SETUP, STEP} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic        winner;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [7:0]  icnt_q, icnt_d;
    logic [7:0]  step_q, step_d;
    logic [17:0] vec_q, vec_d;
    logic        last_q, last_d;
    logic        timeout_hit;

    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ready_q, ready_d;
    logic        rv_q, rv_d;
    logic        rid_q, rid_d;
    logic [38:0] ry_q, ry_d;
    logic [7:0]  rstep_q, rstep_d;
    logic        rlast_q, rlast_d;
    logic        rto_q, rto_d;
    logic        drst_q, drst_d;
    logic [17:0] dx_q, dx_d;
    logic        cen_q, cen_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        rcnt_d      = rcnt_q;
        icnt_d      = icnt_q;
        step_d      = step_q;
        vec_d       = vec_q;
        last_d      = last_q;
        timeout_hit = 1'b0;
        winner      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    // with a single requester valid, bit 1 alone names it
                    winner  = (&bus.req_valid) ? ptr_q : bus.req_valid[1];
                    owner_d = winner;
                    ptr_d   = ~winner;
                    step_d  = '0;
                    rcnt_d  = '0;
                    state_d = RESET;
                end
            end
            RESET: begin
                if (rcnt_q == 4'(RST_CYCLES - 1)) begin
                    icnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            WAIT: begin
                if (bus.req_valid[owner_q]) begin
                    vec_d   = owner_q ? bus.req_x1 : bus.req_x0;
                    last_d  = bus.req_last[owner_q];
                    state_d = SETUP;
                end else if ({1'b0, icnt_q} + 9'd1 == 9'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    icnt_d = icnt_q + 8'd1;
                end
            end
            SETUP: state_d = STEP;
            STEP: begin
                step_d = step_q + 8'd1;
                if (last_q) begin
                    state_d = IDLE;
                end else begin
                    icnt_d  = '0;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        // registered outputs are decoded from the state being entered
        drst_d  = (state_d == IDLE) || (state_d == RESET);
        grant_d = (state_d == IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
        ready_d = (state_d == WAIT) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
        dx_d    = ((state_d == SETUP) || (state_d == STEP)) ? vec_d : '0;
        cen_d   = (state_d == STEP);
        rv_d    = (state_d == STEP) || timeout_hit;
        rid_d   = rv_d ? owner_q : 1'b0;
        ry_d    = (state_q == SETUP) ? dut_y : '0;
        rstep_d = rv_d ? step_q : '0;
        rlast_d = (state_q == SETUP) ? last_q : timeout_hit;
        rto_d   = timeout_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            rcnt_q  <= '0;
            icnt_q  <= '0;
            step_q  <= '0;
            vec_q   <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
            ready_q <= '0;
            rv_q    <= 1'b0;
            rid_q   <= 1'b0;
            ry_q    <= '0;
            rstep_q <= '0;
            rlast_q <= 1'b0;
            rto_q   <= 1'b0;
            drst_q  <= 1'b1;
            dx_q    <= '0;
            cen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            rcnt_q  <= rcnt_d;
            icnt_q  <= icnt_d;
            step_q  <= step_d;
            vec_q   <= vec_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            ry_q    <= ry_d;
            rstep_q <= rstep_d;
            rlast_q <= rlast_d;
            rto_q   <= rto_d;
            drst_q  <= drst_d;
            dx_q    <= dx_d;
            cen_q   <= cen_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.req_ready   = ready_q;
    assign bus.rsp_valid   = rv_q;
    assign bus.rsp_id      = rid_q;
    assign bus.rsp_y       = ry_q;
    assign bus.rsp_step    = rstep_q;
    assign bus.rsp_last    = rlast_q;
    assign bus.rsp_timeout = rto_q;
    assign dut_rst         = drst_q;
    assign dut_x           = dx_q;
    assign dut_clk_en      = cen_q;

endmodule

// File: tb/tb_bench_step_arbiter.sv
// Bench for bench_step_arbiter with a small gated-clock DUT model:
// y = {edge count[2:0], x[1:0], 16'h0, x}, count cleared by dut_rst.
`timescale 1ns/1ps
module tb_bench_step_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dut_rst;
    logic [17:0] dut_x;
    logic        dut_clk_en;
    logic [38:0] dut_y;
    logic [2:0]  dcnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bench_step_arbiter_if bus ();

    bench_step_arbiter #(.RST_CYCLES(2), .TIMEOUT(255)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dut_rst    (dut_rst),
        .dut_x      (dut_x),
        .dut_clk_en (dut_clk_en),
        .dut_y      (dut_y)
    );

    // gated DUT: one falling edge per enabled cycle
    always @(negedge clk) begin
        if (dut_rst === 1'b1) dcnt <= 3'd0;
        else if (dut_clk_en === 1'b1) dcnt <= dcnt + 3'd1;
    end
    assign dut_y = {dcnt, dut_x[1:0], 16'h0000, dut_x};

    typedef struct {
        logic [1:0]  vld;
        logic [17:0] x0;
        logic [1:0]  last;
        logic [1:0]  e_grant;
        logic [1:0]  e_ready;
        logic        e_drst;
        logic        e_cen;
        logic [17:0] e_dx;
        logic        e_rv;
        logic [38:0] e_ry;
        logic [7:0]  e_step;
        logic        e_rlast;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [38:0] y_of(input logic [2:0] n, input logic [17:0] x);
        return {n, x[1:0], 16'h0000, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"},   64'(bus.grant), 64'd0);
        chk({tag, "_ready"},   64'(bus.req_ready), 64'd0);
        chk({tag, "_rv"},      64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rid"},     64'(bus.rsp_id), 64'd0);
        chk({tag, "_ry"},      64'(bus.rsp_y), 64'd0);
        chk({tag, "_rstep"},   64'(bus.rsp_step), 64'd0);
        chk({tag, "_rlast"},   64'(bus.rsp_last), 64'd0);
        chk({tag, "_rto"},     64'(bus.rsp_timeout), 64'd0);
        chk({tag, "_dx"},      64'(dut_x), 64'd0);
        chk({tag, "_cen"},     64'(dut_clk_en), 64'd0);
        chk({tag, "_drst"},    64'(dut_rst), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, 64'(bus.rsp_valid), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g [3];
        int  n, prev, cyc, nrsp;
        bit  bad;

        tbl[0] = '{2'b01, 18'h00003, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 18'h0, 1'b0, 39'h0, 8'd0, 1'b0};
        tbl[1] = '{2'b01, 18'h00003, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 18'h0, 1'b0, 39'h0, 8'd0, 1'b0};
        tbl[2] = '{2'b01, 18'h00003, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 18'h0, 1'b0, 39'h0, 8'd0, 1'b0};
        tbl[3] = '{2'b01, 18'h00003, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 18'h3, 1'b0, 39'h0, 8'd0, 1'b0};
        tbl[4] = '{2'b00, 18'h00000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 18'h3, 1'b1,
                   y_of(3'd0, 18'h00003), 8'd0, 1'b1};
        tbl[5] = '{2'b00, 18'h00000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 18'h0, 1'b0, 39'h0, 8'd0, 1'b0};
        tbl[6] = '{2'b00, 18'h00000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 18'h0, 1'b0, 39'h0, 8'd0, 1'b0};

        bus.req_valid = '0;
        bus.req_x0    = '0;
        bus.req_x1    = '0;
        bus.req_last  = '0;

        // reset held with random requests
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 2'($urandom);
            bus.req_x0    = 18'($urandom);
            bus.req_x1    = 18'($urandom);
            bus.req_last  = 2'($urandom);
            tick();
            chk_reset_outputs($sformatf("rst%0d", i));
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        @(negedge clk);
        rst = 1'b1;

        // single session, cycle by cycle
        for (int i = 0; i < 7; i++) begin
            bus.req_valid = tbl[i].vld;
            bus.req_x0    = tbl[i].x0;
            bus.req_last  = tbl[i].last;
            tick();
            chk($sformatf("row%0d_grant", i), 64'(bus.grant),     64'(tbl[i].e_grant));
            chk($sformatf("row%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].e_ready));
            chk($sformatf("row%0d_drst", i),  64'(dut_rst),       64'(tbl[i].e_drst));
            chk($sformatf("row%0d_cen", i),   64'(dut_clk_en),    64'(tbl[i].e_cen));
            chk($sformatf("row%0d_dx", i),    64'(dut_x),         64'(tbl[i].e_dx));
            chk($sformatf("row%0d_rv", i),    64'(bus.rsp_valid), 64'(tbl[i].e_rv));
            if (tbl[i].e_rv) begin
                chk($sformatf("row%0d_ry", i),    64'(bus.rsp_y),    64'(tbl[i].e_ry));
                chk($sformatf("row%0d_step", i),  64'(bus.rsp_step), 64'(tbl[i].e_step));
                chk($sformatf("row%0d_rlast", i), 64'(bus.rsp_last), 64'(tbl[i].e_rlast));
                chk($sformatf("row%0d_rid", i),   64'(bus.rsp_id),   64'd0);
                chk($sformatf("row%0d_rto", i),   64'(bus.rsp_timeout), 64'd0);
            end
        end

        // contention from reset: 01, 10, 01
        do_reset();
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        bus.req_valid = 2'b11;
        bus.req_last  = 2'b11;
        bus.req_x0    = 18'h00001;
        bus.req_x1    = 18'h00002;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            do begin tick(); n++; end while (bus.grant == 2'b00 && n < 20);
            chk($sformatf("contend_grant%0d", g), 64'(bus.grant), 64'(exp_g[g]));
            bad = 1'b0;
            n = 0;
            while (bus.grant != 2'b00 && n < 20) begin
                if ((bus.req_ready & ~bus.grant) != 2'b00) bad = 1'b1;
                tick();
                n++;
            end
            chk($sformatf("contend_nonowner_ready%0d", g), 64'(bad), 64'd0);
            chk($sformatf("contend_session_end%0d", g), 64'(bus.grant), 64'd0);
        end
        bus.req_valid = '0;

        // idle gap just short of timeout, accept on the expiry edge, then timeout
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_last  = 2'b00;
        bus.req_x0    = 18'h00005;
        wait_rsp("to_step0_valid");
        chk("to_step0_y", 64'(bus.rsp_y), 64'(y_of(3'd0, 18'h00005)));
        chk("to_step0_last", 64'(bus.rsp_last), 64'd0);
        bus.req_valid = 2'b00;
        bad = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b0) bad = 1'b1;
        end
        chk("to_gap_quiet", 64'(bad), 64'd0);
        bus.req_valid = 2'b01;
        bus.req_x0    = 18'h2A5A5;
        tick();
        chk("to_expiry_accept_norsp", 64'(bus.rsp_valid), 64'd0);
        chk("to_expiry_accept_grant", 64'(bus.grant), 64'b01);
        tick();
        chk("to_step1_valid", 64'(bus.rsp_valid), 64'd1);
        chk("to_step1_timeout", 64'(bus.rsp_timeout), 64'd0);
        chk("to_step1_step", 64'(bus.rsp_step), 64'd1);
        chk("to_step1_y", 64'(bus.rsp_y), 64'(y_of(3'd1, 18'h2A5A5)));
        bus.req_valid = 2'b00;
        n = 0;
        do begin tick(); n++; end while (bus.rsp_valid !== 1'b1 && n < 300);
        chk("to_cycles", 64'(n), 64'd256);
        chk("to_flag", 64'(bus.rsp_timeout), 64'd1);
        chk("to_last", 64'(bus.rsp_last), 64'd1);
        chk("to_y", 64'(bus.rsp_y), 64'd0);
        chk("to_id", 64'(bus.rsp_id), 64'd0);
        chk("to_grant", 64'(bus.grant), 64'd0);
        tick();
        chk("to_pulse_once", 64'(bus.rsp_valid), 64'd0);

        // reset in the STEP cycle while the pointer favours req1
        bus.req_valid = 2'b01;
        bus.req_last  = 2'b11;
        bus.req_x0    = 18'h00007;
        wait_rsp("rs_step_valid");
        rst = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        chk("rs_rv_drop", 64'(bus.rsp_valid), 64'd0);
        chk("rs_drst", 64'(dut_rst), 64'd1);
        chk("rs_cen", 64'(dut_clk_en), 64'd0);
        chk("rs_grant", 64'(bus.grant), 64'd0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rs_after_grant", 64'(bus.grant), 64'b01);
        bus.req_valid = 2'b00;

        // 257 steps in one session: step wraps, 3-cycle cadence
        do_reset();
        bus.req_valid = 2'b10;
        bus.req_last  = 2'b00;
        bus.req_x1    = 18'h00011;
        nrsp = 0;
        cyc  = 0;
        prev = 0;
        while (nrsp < 257 && cyc < 1000) begin
            tick();
            cyc++;
            if (bus.rsp_valid === 1'b1) begin
                chk($sformatf("wrap_step%0d", nrsp), 64'(bus.rsp_step), 64'(nrsp % 256));
                chk($sformatf("wrap_last%0d", nrsp), 64'(bus.rsp_last), 64'(nrsp == 256));
                if (nrsp > 0) chk($sformatf("wrap_gap%0d", nrsp), 64'(cyc - prev), 64'd3);
                prev = cyc;
                nrsp++;
                if (nrsp == 256) bus.req_last = 2'b10;
                if (nrsp == 257) bus.req_valid = 2'b00;
            end
        end
        chk("wrap_count", 64'(nrsp), 64'd257);
        chk("wrap_id", 64'(bus.rsp_id), 64'd1);
        tick();
        chk("wrap_end_grant", 64'(bus.grant), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
